carfield_mailbox_responder: RTL

Dual-port register-bus mailbox responder, the target end of the narrow A32/D32 register bus at the OT mailbox window. Port A faces the host (Cheshire) and port B faces the security island. Each port pushes 32-bit messages into a FIFO that the other port pops. A level interrupt tells each side that inbound messages are pending; the port-A interrupt drives the host's mailbox external interrupt.

---
 rtl/carfield_mailbox_responder.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/carfield_mailbox_responder.sv
// Dual-port register-bus mailbox: two opposite-direction message FIFOs, one
// access FSM per port, and level interrupts flagging pending inbound messages.

package carfield_mailbox_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } carfield_a32_d32_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } carfield_a32_d32_reg_rsp_t;
endpackage

module carfield_mailbox_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2,
  parameter int unsigned LvlW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  logic [31:0]     push_data,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [LvlW-1:0] level,
  output logic [31:0]     head,
  output logic            empty_next
);
  logic [31:0]     mem [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [LvlW-1:0] level_next;

  assign full  = (level == LvlW'(Depth));
  assign empty = (level == '0);
  assign head  = mem[rptr];

  // Ports only raise push when not full and pop when not empty.
  always_comb begin
    level_next = level;
    if (flush)             level_next = '0;
    else if (push && !pop) level_next = level + LvlW'(1);
    else if (pop && !push) level_next = level - LvlW'(1);
  end

  assign empty_next = (level_next == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      level <= level_next;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PtrW'(1);
        if (pop)  rptr <= rptr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wptr] <= push_data;
  end
endmodule

// state | meaning
// IDLE  | waiting for valid; decode and commit side effects on the valid cycle
// RESP  | ready high for one cycle with rdata/error, then back to IDLE
module carfield_mailbox_port #(
  parameter int unsigned LvlW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_offset,
  input  logic [1:0]      req_ctrl,
  input  logic [3:0]      req_wstrb,
  output logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_error,
  input  logic            tx_full,
  input  logic [LvlW-1:0] tx_level,
  input  logic            rx_empty,
  input  logic [LvlW-1:0] rx_level,
  input  logic [31:0]     rx_head,
  input  logic            rx_empty_next,
  output logic            tx_push,
  output logic            rx_pop,
  output logic            rx_flush,
  output logic            irq
);
  typedef enum logic {IDLE, RESP} state_e;

  state_e      state;
  logic        commit;
  logic        irq_en;
  logic        irq_en_we;
  logic        irq_en_next;
  logic        rd_error;
  logic [31:0] rd_data;
  logic [31:0] status;

  assign commit = (state == IDLE) && req_valid;

  always_comb begin
    status             = '0;
    status[0]          = rx_empty;
    status[1]          = tx_full;
    status[8 +: LvlW]  = rx_level;
    status[16 +: LvlW] = tx_level;
  end

  always_comb begin
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    rx_flush  = 1'b0;
    irq_en_we = 1'b0;
    rd_data   = '0;
    rd_error  = 1'b0;
    case (req_offset)
      3'd0: begin
        if (req_write) begin
          if (req_wstrb == 4'hF && !tx_full) tx_push = commit;
          else rd_error = 1'b1;
        end
      end
      3'd1: begin
        if (req_write || rx_empty) begin
          rd_error = 1'b1;
        end else begin
          rx_pop  = commit;
          rd_data = rx_head;
        end
      end
      3'd2: begin
        if (req_write) rd_error = 1'b1;
        else rd_data = status;
      end
      3'd3: begin
        if (req_write) begin
          if (req_wstrb[0]) begin
            irq_en_we = commit;
            rx_flush  = commit & req_ctrl[1];
          end
        end else begin
          rd_data = {31'd0, irq_en};
        end
      end
      default: rd_error = 1'b1;
    endcase
  end

  assign irq_en_next = irq_en_we ? req_ctrl[0] : irq_en;

  // Interrupt is built from next-cycle occupancy so it tracks the FIFO level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rsp_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq_en <= irq_en_next;
      irq    <= irq_en_next & ~rx_empty_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= RESP;
            rsp_ready <= 1'b1;
            rsp_rdata <= rd_data;
            rsp_error <= rd_error;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_ready <= 1'b0;
          rsp_rdata <= '0;
          rsp_error <= 1'b0;
        end
      endcase
    end
  end
endmodule

module carfield_mailbox_responder #(
  parameter int unsigned Depth = 4,
  parameter type reg_req_t = carfield_mailbox_pkg::carfield_a32_d32_reg_req_t,
  parameter type reg_rsp_t = carfield_mailbox_pkg::carfield_a32_d32_reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t a_reg_req_i,
  output reg_rsp_t a_reg_rsp_o,
  input  reg_req_t b_reg_req_i,
  output reg_rsp_t b_reg_rsp_o,
  output logic     a_irq_o,
  output logic     b_irq_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic            ab_push, ab_pop, ab_flush, ab_full, ab_empty, ab_empty_next;
  logic            ba_push, ba_pop, ba_flush, ba_full, ba_empty, ba_empty_next;
  logic [LvlW-1:0] ab_level, ba_level;
  logic [31:0]     ab_head, ba_head;
  logic            a_ready, a_error, b_ready, b_error;
  logic [31:0]     a_rdata, b_rdata;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{a_reg_req_i.addr[31:5], a_reg_req_i.addr[1:0],
                              b_reg_req_i.addr[31:5], b_reg_req_i.addr[1:0]};

  carfield_mailbox_fifo #(.Depth(Depth), .PtrW(PtrW), .LvlW(LvlW)) u_fifo_ab (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (ab_push),
    .push_data  (a_reg_req_i.wdata),
    .pop        (ab_pop),
    .flush      (ab_flush),
    .full       (ab_full),
    .empty      (ab_empty),
    .level      (ab_level),
    .head       (ab_head),
    .empty_next (ab_empty_next)
  );

  carfield_mailbox_fifo #(.Depth(Depth), .PtrW(PtrW), .LvlW(LvlW)) u_fifo_ba (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (ba_push),
    .push_data  (b_reg_req_i.wdata),
    .pop        (ba_pop),
    .flush      (ba_flush),
    .full       (ba_full),
    .empty      (ba_empty),
    .level      (ba_level),
    .head       (ba_head),
    .empty_next (ba_empty_next)
  );

  carfield_mailbox_port #(.LvlW(LvlW)) u_port_a (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid     (a_reg_req_i.valid),
    .req_write     (a_reg_req_i.write),
    .req_offset    (a_reg_req_i.addr[4:2]),
    .req_ctrl      (a_reg_req_i.wdata[1:0]),
    .req_wstrb     (a_reg_req_i.wstrb),
    .rsp_ready     (a_ready),
    .rsp_rdata     (a_rdata),
    .rsp_error     (a_error),
    .tx_full       (ab_full),
    .tx_level      (ab_level),
    .rx_empty      (ba_empty),
    .rx_level      (ba_level),
    .rx_head       (ba_head),
    .rx_empty_next (ba_empty_next),
    .tx_push       (ab_push),
    .rx_pop        (ba_pop),
    .rx_flush      (ba_flush),
    .irq           (a_irq_o)
  );

  carfield_mailbox_port #(.LvlW(LvlW)) u_port_b (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid     (b_reg_req_i.valid),
    .req_write     (b_reg_req_i.write),
    .req_offset    (b_reg_req_i.addr[4:2]),
    .req_ctrl      (b_reg_req_i.wdata[1:0]),
    .req_wstrb     (b_reg_req_i.wstrb),
    .rsp_ready     (b_ready),
    .rsp_rdata     (b_rdata),
    .rsp_error     (b_error),
    .tx_full       (ba_full),
    .tx_level      (ba_level),
    .rx_empty      (ab_empty),
    .rx_level      (ab_level),
    .rx_head       (ab_head),
    .rx_empty_next (ab_empty_next),
    .tx_push       (ba_push),
    .rx_pop        (ab_pop),
    .rx_flush      (ab_flush),
    .irq           (b_irq_o)
  );

  always_comb begin
    a_reg_rsp_o       = '0;
    a_reg_rsp_o.rdata = a_rdata;
    a_reg_rsp_o.error = a_error;
    a_reg_rsp_o.ready = a_ready;
    b_reg_rsp_o       = '0;
    b_reg_rsp_o.rdata = b_rdata;
    b_reg_rsp_o.error = b_error;
    b_reg_rsp_o.ready = b_ready;
  end
endmodule
